pdm_demod: RTL
==============

PDM_DEMOD -- requirements
Module: pdm_demod

Interface
REQ-001 Parameter LOG2_DECIM, default 5, log2 of decimation ratio R (R = 32).
REQ-002 Parameter OUT_W, default 10, output sample width; SHALL satisfy 2*LOG2_DECIM >= OUT_W (elaboration error otherwise).
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 en  in  1  sample enable; din accepted only on cycles with en=1.
REQ-006 din  in  1  PDM bitstream (1 = +full scale, 0 = zero).
REQ-007 dout  out  OUT_W  decimated unsigned PCM sample, same scale as the codebase pdm din.
REQ-008 valid  out  1  one-cycle strobe marking a new dout.
REQ-009 settled  out  1  high once the filter transient has passed.

Function
REQ-010 Filter SHALL be a 2nd-order CIC: integrators I1 += din, I2 += I1 on each accepted sample; combs C1 = I2 - I2_prev, C2 = C1 - C1_prev at each decimation tick.
REQ-011 Integrator and comb registers SHALL be ACC_W = 2*LOG2_DECIM+1 bits, unsigned, modulo-2^ACC_W wrap-around; wrap is intended and SHALL NOT be detected or saturated.
REQ-012 Frame counter SHALL count accepted samples 0..R-1 and wrap to 0; en=0 cycles SHALL freeze counter, integrators and combs.
REQ-013 Decimation tick SHALL occur on the edge accepting the sample with counter = R-1; the comb SHALL use I2 including that sample.
REQ-014 On the tick edge, dout SHALL load min(C2 >> (2*LOG2_DECIM - OUT_W), 2^OUT_W - 1); full-scale 1024 (default) saturates to 1023.
REQ-015 valid SHALL be high for exactly the one cycle after the tick edge, low otherwise; no back-pressure.
REQ-016 Latency: valid follows the R-th accepted sample of a frame by one clock.
REQ-017 dout SHALL hold its value between ticks.
REQ-018 settled SHALL rise with the second valid after reset and stay high until reset; the first output after reset is transient (partial window).
REQ-019 rst asserted together with en=1 SHALL take priority; that sample is discarded.

Reset
REQ-020 On rst: counter, I1, I2, I2_prev, C1_prev = 0; dout = 0; valid = 0; settled = 0.
REQ-021 Reset mid-frame SHALL discard the partial frame; the next frame starts at counter 0 on the first accepted sample after rst deasserts.
REQ-022 No output SHALL depend on register initial values other than those set by rst.

Structure
REQ-023 Shared package pdm_pkg SHALL hold OUT_W default (10) and the ACC_W width function; the codebase pdm modulator SHALL import the same OUT_W.
REQ-024 One sub-module, cic_comb (registered difference stage, ACC_W wide), SHALL be instantiated twice; integrators, counter, scaling and saturation remain in pdm_demod.
REQ-025 Target size 120-400 lines RTL; no RAM, no multipliers.

Verification
REQ-026 rst 2 cycles, en=1, din constantly 1 -> valid every 32 cycles; 1st dout = 528 (partial window), 2nd onward = 1023 (saturated); settled rises with the 2nd valid.
REQ-027 din constantly 0 -> every dout = 0, valid period 32 cycles, settled after 2nd valid.
REQ-028 din alternating 1,0 -> from 2nd valid onward dout = 512 exactly.
REQ-029 Loopback: codebase pdm driven with constant 300 -> pdm_demod; after settled, each dout within 300 +/- 32, mean of 16 outputs within 300 +/- 2.
REQ-030 en=1 every 3rd cycle, din = 1 -> valid spacing 96 cycles, outputs identical to REQ-026 sequence.
REQ-031 rst pulsed after 17 samples of frame 3 -> valid/settled/dout = 0 next cycle; next valid exactly 32 accepted samples later, transient repeats as in REQ-026.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared PDM definitions: default PCM width and CIC accumulator sizing.
// The pdm modulator and pdm_demod both import PDM_OUT_W so their scales match.
package pdm_pkg;

    localparam int PDM_OUT_W      = 10;
    localparam int PDM_LOG2_DECIM = 5;

    // A 2nd-order CIC with ratio 2^log2_decim has gain R^2, so 2*log2 bits
    // hold the full-scale value and one extra bit holds the exact value R^2.
    function automatic int cic_acc_w(input int log2_decim);
        return 2 * log2_decim + 1;
    endfunction

endpackage

// File: rtl/pdm_demod_cic_comb.sv
// One CIC comb stage: y = x - x_prev, where x_prev is captured on each decimation tick.
// The difference is combinational so that cascaded combs settle within the tick cycle.
module cic_comb
    import pdm_pkg::*;
#(
    parameter int ACC_W = cic_acc_w(PDM_LOG2_DECIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [ACC_W-1:0] x,
    output logic [ACC_W-1:0] y
);

    logic [ACC_W-1:0] x_prev_p0;

    // ---- delay register, updated once per output sample
    always_ff @(posedge clk) begin
        if (rst) begin
            x_prev_p0 <= '0;
        end else if (tick) begin
            x_prev_p0 <= x;
        end
    end

    // Modulo-2^ACC_W subtraction; wrap-around is intentional.
    assign y = x - x_prev_p0;

endmodule

// File: rtl/pdm_demod.sv
// PDM-to-PCM demodulator: 2nd-order CIC decimator by 2^LOG2_DECIM with a
// saturating output scaler, sample strobe and settled flag.
module pdm_demod
    import pdm_pkg::*;
#(
    parameter int LOG2_DECIM = PDM_LOG2_DECIM,
    parameter int OUT_W      = PDM_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [OUT_W-1:0] dout,
    output logic             valid,
    output logic             settled
);

    localparam int ACC_W   = cic_acc_w(LOG2_DECIM);
    localparam int SHIFT   = 2 * LOG2_DECIM - OUT_W;
    localparam int SAT_MAX = (1 << OUT_W) - 1;
    localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;

    if (2 * LOG2_DECIM < OUT_W) begin : g_bad_cfg
        $error("pdm_demod: OUT_W exceeds 2*LOG2_DECIM");
    end

    // Full-scale input yields exactly 2^(2*LOG2_DECIM), one code above the
    // largest OUT_W value after scaling, so clamp rather than wrap.
    function automatic logic [OUT_W-1:0] scale_sat(input logic [ACC_W-1:0] c);
        logic [ACC_W-1:0] s;
        s = c >> SHIFT;
        if (s > ACC_W'(SAT_MAX)) begin
            return '1;
        end
        return s[OUT_W-1:0];
    endfunction

    logic [LOG2_DECIM-1:0] cnt_p0;
    logic [ACC_W-1:0]      i1_p0;
    logic [ACC_W-1:0]      i2_p0;
    logic [ACC_W-1:0]      i1_nxt;
    logic [ACC_W-1:0]      i2_nxt;
    logic [ACC_W-1:0]      c1;
    logic [ACC_W-1:0]      c2;
    logic                  tick;
    logic [OUT_W-1:0]      dout_p1;
    logic                  vld_p1;
    logic                  first_done_p1;
    logic                  settled_p1;

    // I2 accumulates the already-updated I1 so the comb sees the sample
    // accepted on the tick edge itself.
    always_comb begin
        i1_nxt = i1_p0 + ACC_W'(din);
        i2_nxt = i2_p0 + i1_nxt;
        tick   = en && (cnt_p0 == CNT_LAST);
    end

    // ---- stage p0: frame counter and integrators, advance on accepted samples
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
            i1_p0  <= '0;
            i2_p0  <= '0;
        end else if (en) begin
            cnt_p0 <= cnt_p0 + LOG2_DECIM'(1);
            i1_p0  <= i1_nxt;
            i2_p0  <= i2_nxt;
        end
    end

    cic_comb #(
        .ACC_W (ACC_W)
    ) u_comb1 (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .x    (i2_nxt),
        .y    (c1)
    );

    cic_comb #(
        .ACC_W (ACC_W)
    ) u_comb2 (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .x    (c1),
        .y    (c2)
    );

    // ---- stage p1: decimated output, strobe and settle tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_p1       <= '0;
            vld_p1        <= 1'b0;
            first_done_p1 <= 1'b0;
            settled_p1    <= 1'b0;
        end else begin
            vld_p1 <= tick;
            if (tick) begin
                dout_p1       <= scale_sat(c2);
                first_done_p1 <= 1'b1;
                // The first output only saw a partial window; the second is clean.
                if (first_done_p1) begin
                    settled_p1 <= 1'b1;
                end
            end
        end
    end

    assign dout    = dout_p1;
    assign valid   = vld_p1;
    assign settled = settled_p1;

endmodule
